uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among N_REQ requesters, each presenting a data word with a level request. Round-robin arbitration picks a winner, latches its data, and pulses the transmitter's enable. The block then tracks the transmitter's busy flag through one complete frame and reports capture, completion and timeout per requester. It sits between client logic and the UART transmit datapath; it is the only driver of that datapath's enable and data inputs.

Parameters:
N_REQ, 4, number of requesters (2..8)
D_WIDTH, 4, data word width; must match the transmitter
WAIT_LIMIT, 7, max cycles in WAIT_BUSY before timeout (1..255)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  level request, bit i for requester i
req_data  in  N_REQ*D_WIDTH  requester i word at [i*D_WIDTH +: D_WIDTH]
ack  out  N_REQ  one-cycle pulse: requester i's word captured
done  out  N_REQ  one-cycle pulse: requester i's frame finished
err  out  1  one-cycle pulse: transmitter never went busy
uart_tx_ena  out  1  to transmitter enable
uart_tx_data  out  D_WIDTH  to transmitter data
uart_tx_busy  in  1  from transmitter busy flag
grant_idx  out  clog2(N_REQ)  index of current/last winner
active  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ptr=0; grant_idx=0; uart_tx_data=0; all outputs 0.
- All outputs are registered.
- ptr holds the highest-priority index. The search order is ptr, ptr+1, ..., wrapping modulo N_REQ.
- IDLE: if any req bit is set, the winner is the first set bit in search order.
  - On that edge: grant_idx=winner, uart_tx_data=winner's word, ack[winner]=1, uart_tx_ena=1, go LAUNCH.
  - With no req, stay in IDLE.
- LAUNCH (one cycle): uart_tx_ena and ack are high for exactly this cycle. Next edge drops both and goes to WAIT_BUSY with wcnt=0.
- WAIT_BUSY:
  - uart_tx_busy=1 -> go WAIT_DONE.
  - Otherwise wcnt increments; when wcnt reaches WAIT_LIMIT -> pulse err, set ptr=grant_idx+1 (mod N_REQ), go IDLE.
- WAIT_DONE:
  - uart_tx_busy=0 -> pulse done[grant_idx], set ptr=grant_idx+1 (mod N_REQ), go IDLE.
  - There is no timeout in this state.
- Minimum gap: a new grant is possible on the edge after done. Back-to-back frames therefore have IDLE->LAUNCH latency of 1 cycle.
- uart_tx_data holds its value from capture until the next capture.
- req_data is sampled only on the capture edge. Changes after ack are ignored.
- A requester must drop req on the cycle after ack. A req still high in IDLE is treated as a new request.
- A req deasserted before capture is simply not granted. No state is kept for it.
- Simultaneous requests: only the winner gets ack. Losers stay pending and get no pulse.
- Busy already high in IDLE (frame from a previous owner): the block does not launch until busy=0. The IDLE grant is gated by !uart_tx_busy.
- At most one bit of ack/done is set at any time. ack, done and err never coincide.
- Mid-operation reset: returns to IDLE immediately and drops uart_tx_ena. No done or err is issued for the aborted frame.

Decomposition:
- Shared package uart_pkg holds:
  - state enum arb_state_t {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE};
  - constant UART_D_WIDTH=4;
  - function rr_pick(req, ptr), returning winner index and a valid flag.
- One natural sub-module: rr_pick_n, a combinational round-robin selector (req, ptr -> idx, valid), reusable by other arbiters.

Test Plan:
- Single request: req=0001, data0=0xA -> ack=0001 one cycle after req; uart_tx_ena one-cycle pulse; uart_tx_data=0xA. With a transmitter model (busy for 7 cycles), done=0001 on the edge after busy falls; active high throughout.
- All four req with data 1,2,3,4, each dropped after its ack -> grant order 0,1,2,3. uart_tx_data sequence 1,2,3,4, four done pulses, no err.
- Fairness: req0 held high continuously, req2 raised during frame 0 -> next grant is 2, then 0. Requester 0 never wins twice while 2 waits.
- Timeout: busy tied 0, req=0100 -> ack[2], then err pulses WAIT_LIMIT cycles after leaving LAUNCH. State returns to IDLE, done stays 0, ptr=3.
- Reset mid-frame: rst low during WAIT_DONE -> all outputs 0 asynchronously. After release, no done is issued; a new req0 is granted first (ptr=0).
- Busy-gate: busy held 1 in IDLE with req=0010 -> no ack until busy falls, then ack[1] on the next edge.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Purpose : Shared definitions for the UART transmit arbiter: FSM state
//           encoding, the default transmitter word width and a generic
//           round-robin pick function usable by any arbiter up to 8 ways.
// Contents: arb_state_t, UART_D_WIDTH, RR_MAX, rr_pick_t, rr_pick().
package uart_pkg;

    localparam int UART_D_WIDTH = 4;
    localparam int RR_MAX       = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req in the order ptr, ptr+1, ... wrapping at n.
    // Only the low n bits of req are considered; ptr must be below n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n);
        rr_pick_t   r;
        logic [3:0] j;
        r = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            // ptr < n and k < n, so a single subtraction wraps correctly
            j = {1'b0, ptr} + 4'(k);
            if (j >= 4'(n)) j = j - 4'(n);
            if ((k < n) && !r.valid && req[j[2:0]]) begin
                r.valid = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Purpose : Bundles the requester handshake and transmitter-side signals of
//           the UART transmit arbiter.
// Modports: slave  - the arbiter (drives ack/done/err/enable/data/status)
//           master - clients plus transmitter (drive req/req_data/busy)
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = UART_D_WIDTH
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         req;
    logic [N_REQ*D_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]         ack;
    logic [N_REQ-1:0]         done;
    logic                     err;
    logic                     uart_tx_ena;
    logic [D_WIDTH-1:0]       uart_tx_data;
    logic                     uart_tx_busy;
    logic [IDX_W-1:0]         grant_idx;
    logic                     active;

    modport slave (
        input  req, req_data, uart_tx_busy,
        output ack, done, err, uart_tx_ena, uart_tx_data, grant_idx, active
    );

    modport master (
        output req, req_data, uart_tx_busy,
        input  ack, done, err, uart_tx_ena, uart_tx_data, grant_idx, active
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose : Combinational round-robin selector, reusable by other arbiters.
// Ports   : i_req   - request vector, bit i for requester i
//           i_ptr   - highest-priority index
//           o_idx   - winner index (valid only when o_valid)
//           o_valid - at least one request is set
module rr_pick_n
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [RR_MAX-1:0] w_req;
    logic [2:0]        w_ptr;
    rr_pick_t          w_pick;

    always_comb begin
        w_req               = '0;
        w_req[N_REQ-1:0]    = i_req;
        w_ptr               = '0;
        w_ptr[IDX_W-1:0]    = i_ptr;
    end

    assign w_pick  = rr_pick(w_req, w_ptr, N_REQ);
    assign o_valid = w_pick.valid;

    // Narrow the 3-bit package index down to this arbiter's index width.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick.idx == 3'(i)) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose : Shares one UART transmitter among N_REQ requesters. A round-robin
//           winner is captured, the transmitter enable is pulsed for one
//           cycle, and the transmitter busy flag is followed through one
//           frame, reporting capture (ack), completion (done) or a transmitter
//           that never started (err).
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-low reset
//           bus - uart_tx_arbiter_if.slave (requests, status, transmitter)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int D_WIDTH    = UART_D_WIDTH,
    parameter int WAIT_LIMIT = 7
)(
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t         r_state, w_state_nx;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nx;
    logic [IDX_W-1:0]   r_grant, w_grant_nx;
    logic [D_WIDTH-1:0] r_data, w_data_nx;
    logic [N_REQ-1:0]   r_ack, w_ack_nx;
    logic [N_REQ-1:0]   r_done, w_done_nx;
    logic               r_err, w_err_nx;
    logic               r_ena, w_ena_nx;
    logic               r_active, w_active_nx;
    logic [7:0]         r_wcnt, w_wcnt_nx;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_vld;
    logic [IDX_W-1:0]   w_ptr_after;

    rr_pick_n #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_vld)
    );

    // The requester after the one just served gets top priority next.
    assign w_ptr_after = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_data   <= '0;
            r_ack    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_ena    <= 1'b0;
            r_active <= 1'b0;
            r_wcnt   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_ptr    <= w_ptr_nx;
            r_grant  <= w_grant_nx;
            r_data   <= w_data_nx;
            r_ack    <= w_ack_nx;
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
            r_ena    <= w_ena_nx;
            r_active <= w_active_nx;
            r_wcnt   <= w_wcnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_grant_nx = r_grant;
        w_data_nx  = r_data;
        w_ack_nx   = '0;
        w_done_nx  = '0;
        w_err_nx   = 1'b0;
        w_ena_nx   = 1'b0;
        w_wcnt_nx  = r_wcnt;

        case (r_state)
            IDLE: begin
                // A frame still running for a previous owner blocks launch.
                if (w_pick_vld && !bus.uart_tx_busy) begin
                    w_grant_nx           = w_pick_idx;
                    w_data_nx            = bus.req_data[int'(w_pick_idx)*D_WIDTH +: D_WIDTH];
                    w_ack_nx[w_pick_idx] = 1'b1;
                    w_ena_nx             = 1'b1;
                    w_state_nx           = LAUNCH;
                end
            end
            LAUNCH: begin
                w_wcnt_nx  = '0;
                w_state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.uart_tx_busy) begin
                    w_state_nx = WAIT_DONE;
                end else if (r_wcnt == 8'(WAIT_LIMIT - 1)) begin
                    w_err_nx   = 1'b1;
                    w_ptr_nx   = w_ptr_after;
                    w_state_nx = IDLE;
                end else begin
                    w_wcnt_nx = r_wcnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_tx_busy) begin
                    w_done_nx[r_grant] = 1'b1;
                    w_ptr_nx           = w_ptr_after;
                    w_state_nx         = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase

        w_active_nx = (w_state_nx != IDLE);
    end

    assign bus.ack          = r_ack;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.uart_tx_ena  = r_ena;
    assign bus.uart_tx_data = r_data;
    assign bus.grant_idx    = r_grant;
    assign bus.active       = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : Self-checking bench for uart_tx_arbiter (N_REQ=4, D_WIDTH=4,
//           WAIT_LIMIT=7) with a simple transmitter model that holds busy
//           for 7 cycles after each enable pulse.
module tb_uart_tx_arbiter;

    localparam int N_REQ      = 4;
    localparam int D_WIDTH    = 4;
    localparam int WAIT_LIMIT = 7;

    typedef struct {
        int         idx;
        logic [3:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   busy_force;   // -1: transmitter model, 0/1: busy forced
    int   tx_cnt;
    int   err_cnt;
    int   excl_viol;
    exp_t sb[$];

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .D_WIDTH(D_WIDTH)) bus ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .D_WIDTH(D_WIDTH), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter: busy rises at the negedge of the enable cycle, lasts 7 cycles.
    always @(negedge clk) begin
        if (busy_force >= 0) begin
            tx_cnt           <= 0;
            bus.uart_tx_busy <= (busy_force == 1);
        end else if (!rst) begin
            tx_cnt           <= 0;
            bus.uart_tx_busy <= 1'b0;
        end else if (bus.uart_tx_ena) begin
            tx_cnt           <= 6;
            bus.uart_tx_busy <= 1'b1;
        end else if (tx_cnt > 0) begin
            tx_cnt           <= tx_cnt - 1;
            bus.uart_tx_busy <= 1'b1;
        end else begin
            bus.uart_tx_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.err === 1'b1) err_cnt <= err_cnt + 1;
        if ($countones(bus.ack) > 1 || $countones(bus.done) > 1 ||
            (int'(bus.ack != 0) + int'(bus.done != 0) + int'(bus.err)) > 1)
            excl_viol <= excl_viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req    = '0;
        busy_force = -1;
        rst        = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic wait_ack(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.ack != 0) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok, output int cyc, output int inact);
        ok    = 1'b0;
        cyc   = 0;
        inact = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.done != 0) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
            if (bus.active !== 1'b1) inact++;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        busy_force = -1;
        bus.req      = '0;
        bus.req_data = '0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ack, bus.done, bus.err, bus.uart_tx_ena, bus.uart_tx_data,
             bus.grant_idx, bus.active} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: ack=%b done=%b err=%b ena=%b data=%h grant=%0d active=%b, required all zero",
                     bus.ack, bus.done, bus.err, bus.uart_tx_ena, bus.uart_tx_data,
                     bus.grant_idx, bus.active);
        end
        tick();
        tick();
        n_cmp++;
        if ({bus.ack, bus.uart_tx_ena, bus.active, bus.uart_tx_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_held: ack=%b ena=%b active=%b data=%h, required zero",
                     bus.ack, bus.uart_tx_ena, bus.active, bus.uart_tx_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        bit   ok;
        int   cyc, inact;
        exp_t e;
        do_reset();
        sb.push_back('{0, 4'hA});
        bus.req_data = 16'h000A;
        bus.req      = 4'b0001;
        wait_ack(ok, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || cyc != 1) begin
            n_bad++;
            $display("FAIL single_ack_latency: seen=%0b cycles=%0d, required 1", ok, cyc);
        end
        n_cmp++;
        if (bus.ack !== 4'(1 << e.idx) || bus.grant_idx !== 2'(e.idx) ||
            bus.uart_tx_data !== e.data || bus.uart_tx_ena !== 1'b1 || bus.active !== 1'b1) begin
            n_bad++;
            $display("FAIL single_capture: ack=%b grant=%0d data=%h ena=%b active=%b, required ack=%b grant=%0d data=%h ena=1 active=1",
                     bus.ack, bus.grant_idx, bus.uart_tx_data, bus.uart_tx_ena, bus.active,
                     4'(1 << e.idx), e.idx, e.data);
        end
        bus.req      = '0;
        bus.req_data = 16'hFFFF;
        tick();
        n_cmp++;
        if (bus.uart_tx_ena !== 1'b0 || bus.ack !== 4'b0000 || bus.active !== 1'b1) begin
            n_bad++;
            $display("FAIL single_pulse_width: ena=%b ack=%b active=%b, required ena=0 ack=0 active=1",
                     bus.uart_tx_ena, bus.ack, bus.active);
        end
        // done lands 8 cycles after ack; one cycle was already consumed above.
        wait_done(ok, cyc, inact);
        n_cmp++;
        if (!ok || cyc != 7 || inact != 0 || bus.done !== 4'b0001 ||
            bus.active !== 1'b0 || bus.uart_tx_data !== 4'hA) begin
            n_bad++;
            $display("FAIL single_done: seen=%0b cycles=%0d inactive=%0d done=%b active=%b data=%h, required cycles=7 inactive=0 done=0001 active=0 data=a",
                     ok, cyc, inact, bus.done, bus.active, bus.uart_tx_data);
        end
    endtask

    task automatic test_all_four();
        bit   ok;
        int   cyc, inact, err0;
        exp_t e;
        do_reset();
        err0 = err_cnt;
        for (int i = 0; i < 4; i++) sb.push_back('{i, 4'(i + 1)});
        bus.req_data = 16'h4321;
        bus.req      = 4'b1111;
        for (int f = 0; f < 4; f++) begin
            wait_ack(ok, cyc);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || cyc != 1 || bus.grant_idx !== 2'(e.idx) ||
                bus.uart_tx_data !== e.data || bus.ack !== 4'(1 << e.idx)) begin
                n_bad++;
                $display("FAIL all4_grant%0d: seen=%0b cycles=%0d grant=%0d data=%h ack=%b, required cycles=1 grant=%0d data=%h",
                         f, ok, cyc, bus.grant_idx, bus.uart_tx_data, bus.ack, e.idx, e.data);
            end
            bus.req[e.idx] = 1'b0;
            wait_done(ok, cyc, inact);
            n_cmp++;
            if (!ok || bus.done !== 4'(1 << e.idx)) begin
                n_bad++;
                $display("FAIL all4_done%0d: seen=%0b done=%b, required %b",
                         f, ok, bus.done, 4'(1 << e.idx));
            end
        end
        tick();
        n_cmp++;
        if (err_cnt != err0) begin
            n_bad++;
            $display("FAIL all4_no_err: err pulses=%0d, required 0", err_cnt - err0);
        end
    endtask

    task automatic test_fairness();
        bit   ok;
        int   cyc, inact;
        exp_t e;
        do_reset();
        bus.req_data = 16'h0905;
        sb.push_back('{0, 4'h5});
        bus.req = 4'b0001;
        for (int f = 0; f < 3; f++) begin
            wait_ack(ok, cyc);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || bus.grant_idx !== 2'(e.idx) || bus.uart_tx_data !== e.data) begin
                n_bad++;
                $display("FAIL fair_grant%0d: seen=%0b grant=%0d data=%h, required grant=%0d data=%h",
                         f, ok, bus.grant_idx, bus.uart_tx_data, e.idx, e.data);
            end
            if (f == 0) begin
                tick();
                tick();
                bus.req[2] = 1'b1;
                sb.push_back('{2, 4'h9});
                sb.push_back('{0, 4'h5});
            end else if (f == 1) begin
                bus.req[2] = 1'b0;
            end else begin
                bus.req = '0;
            end
            wait_done(ok, cyc, inact);
            n_cmp++;
            if (!ok || bus.done !== 4'(1 << e.idx)) begin
                n_bad++;
                $display("FAIL fair_done%0d: seen=%0b done=%b, required %b",
                         f, ok, bus.done, 4'(1 << e.idx));
            end
        end
    endtask

    task automatic test_timeout();
        bit   ok;
        int   cyc, inact, err0, done_seen;
        exp_t e;
        do_reset();
        busy_force   = 0;
        err0         = err_cnt;
        bus.req_data = 16'h0700;
        sb.push_back('{2, 4'h7});
        bus.req = 4'b0100;
        wait_ack(ok, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || bus.ack !== 4'(1 << e.idx) || bus.uart_tx_data !== e.data) begin
            n_bad++;
            $display("FAIL timeout_ack: seen=%0b ack=%b data=%h, required ack=%b data=%h",
                     ok, bus.ack, bus.uart_tx_data, 4'(1 << e.idx), e.data);
        end
        bus.req   = '0;
        ok        = 1'b0;
        cyc       = 0;
        done_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.done != 0) done_seen++;
            if (bus.err === 1'b1) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
        end
        // One cycle in LAUNCH, then WAIT_LIMIT cycles in WAIT_BUSY.
        n_cmp++;
        if (!ok || cyc != WAIT_LIMIT + 1 || done_seen != 0 || bus.active !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_err: seen=%0b cycles=%0d done_pulses=%0d active=%b, required cycles=%0d done_pulses=0 active=0",
                     ok, cyc, done_seen, bus.active, WAIT_LIMIT + 1);
        end
        busy_force = -1;
        tick();
        n_cmp++;
        if (bus.err !== 1'b0 || err_cnt - err0 != 1) begin
            n_bad++;
            $display("FAIL timeout_err_pulse: err=%b pulses=%0d, required err=0 pulses=1",
                     bus.err, err_cnt - err0);
        end
        // Priority now starts at 3, so 3 beats 0.
        bus.req_data = 16'h5004;
        sb.push_back('{3, 4'h5});
        bus.req = 4'b1001;
        wait_ack(ok, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || bus.grant_idx !== 2'(e.idx) || bus.uart_tx_data !== e.data) begin
            n_bad++;
            $display("FAIL timeout_ptr: seen=%0b grant=%0d data=%h, required grant=%0d data=%h",
                     ok, bus.grant_idx, bus.uart_tx_data, e.idx, e.data);
        end
        bus.req = '0;
        wait_done(ok, cyc, inact);
        n_cmp++;
        if (!ok || bus.done !== 4'b1000) begin
            n_bad++;
            $display("FAIL timeout_next_done: seen=%0b done=%b, required 1000", ok, bus.done);
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   cyc, inact, dcount;
        exp_t e;
        do_reset();
        bus.req_data = 16'h0030;
        sb.push_back('{1, 4'h3});
        bus.req = 4'b0010;
        wait_ack(ok, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || bus.grant_idx !== 2'(e.idx) || bus.uart_tx_data !== e.data) begin
            n_bad++;
            $display("FAIL rstmid_grant: seen=%0b grant=%0d data=%h, required grant=%0d data=%h",
                     ok, bus.grant_idx, bus.uart_tx_data, e.idx, e.data);
        end
        bus.req = '0;
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ack, bus.done, bus.err, bus.uart_tx_ena, bus.uart_tx_data,
             bus.grant_idx, bus.active} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_async: ack=%b done=%b err=%b ena=%b data=%h grant=%0d active=%b, required all zero",
                     bus.ack, bus.done, bus.err, bus.uart_tx_ena, bus.uart_tx_data,
                     bus.grant_idx, bus.active);
        end
        tick();
        tick();
        rst    = 1'b1;
        dcount = 0;
        repeat (12) begin
            tick();
            if (bus.done != 0 || bus.err !== 1'b0) dcount++;
        end
        n_cmp++;
        if (dcount != 0) begin
            n_bad++;
            $display("FAIL rstmid_no_done: stray pulses=%0d, required 0", dcount);
        end
        bus.req_data = 16'h00B9;
        sb.push_back('{0, 4'h9});
        bus.req = 4'b0011;
        wait_ack(ok, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || bus.grant_idx !== 2'(e.idx) || bus.uart_tx_data !== e.data) begin
            n_bad++;
            $display("FAIL rstmid_ptr0: seen=%0b grant=%0d data=%h, required grant=%0d data=%h",
                     ok, bus.grant_idx, bus.uart_tx_data, e.idx, e.data);
        end
        bus.req = '0;
        wait_done(ok, cyc, inact);
    endtask

    task automatic test_busy_gate();
        bit   ok;
        int   cyc, inact, acks;
        exp_t e;
        do_reset();
        busy_force   = 1;
        bus.req_data = 16'h00C0;
        sb.push_back('{1, 4'hC});
        bus.req = 4'b0010;
        acks    = 0;
        repeat (6) begin
            tick();
            if (bus.ack != 0) acks++;
        end
        n_cmp++;
        if (acks != 0) begin
            n_bad++;
            $display("FAIL busy_gate_hold: acks while busy=%0d, required 0", acks);
        end
        busy_force = -1;
        wait_ack(ok, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || cyc != 1 || bus.ack !== 4'(1 << e.idx) || bus.uart_tx_data !== e.data) begin
            n_bad++;
            $display("FAIL busy_gate_release: seen=%0b cycles=%0d ack=%b data=%h, required cycles=1 ack=%b data=%h",
                     ok, cyc, bus.ack, bus.uart_tx_data, 4'(1 << e.idx), e.data);
        end
        bus.req = '0;
        wait_done(ok, cyc, inact);
        n_cmp++;
        if (!ok || bus.done !== 4'b0010) begin
            n_bad++;
            $display("FAIL busy_gate_done: seen=%0b done=%b, required 0010", ok, bus.done);
        end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (excl_viol != 0) begin
            n_bad++;
            $display("FAIL exclusive_pulses: overlapping cycles=%0d, required 0", excl_viol);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: entries left=%0d, required 0", sb.size());
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        err_cnt    = 0;
        excl_viol  = 0;
        tx_cnt     = 0;
        busy_force = -1;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_busy_gate();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
